// File: rtl/vga_pkg.sv
// vga_pkg
// Shared types and constants for the pixel framebuffer path. The capture
// stage and the VGA scanout both use fb_addr_t and FB_STRIDE from here so
// the address layout (address = FB_STRIDE*line + x) stays consistent.
// No ports (package).
`timescale 1ns/1ps
package vga_pkg;

  typedef logic [17:0] fb_addr_t;
  typedef logic [10:0] hcnt_t;
  typedef logic [9:0]  vcnt_t;

  // One framebuffer line holds 800 one-bit pixels
  localparam int FB_STRIDE = 800;

  // 800x600@60 timing with a 40 MHz pixel clock
  localparam int DEF_H_VIS = 800;
  localparam int DEF_H_FP  = 40;
  localparam int DEF_H_SW  = 128;
  localparam int DEF_H_BP  = 88;
  localparam int DEF_V_VIS = 600;
  localparam int DEF_V_FP  = 1;
  localparam int DEF_V_SW  = 4;
  localparam int DEF_V_BP  = 23;

  // Vertical position relative to the line-doubled framebuffer window
  typedef enum logic [1:0] {
    V_TOP,
    V_WIN,
    V_BOT
  } vstate_t;

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line
// Fixed-depth shift register used to delay the raw timing flags so they
// line up with data returning from the framebuffer RAM.
// Ports:
//   clk    in   shift clock
//   rst_n  in   asynchronous active-low clear of every stage
//   din    in   WIDTH-bit value entering the line
//   dout   out  din delayed by DEPTH clocks
`timescale 1ns/1ps
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout
// Scans a 1-bit-per-pixel framebuffer out as 800x600@60 VGA. FB_LINES
// framebuffer lines are each shown twice inside a window starting at
// screen line V_OFFSET. Sync and colour leave the block with the same
// latency (RD_LAT+1 clocks after the counter state that produced them).
// Optional build macro: VGA_SCANLINE_EN blanks the second copy of every
// doubled line for a CRT scanline look.
// Ports:
//   vgaclk       in   40 MHz pixel clock
//   reset_n      in   asynchronous active-low reset
//   raddr        out  framebuffer read address
//   rdata        in   framebuffer pixel, valid RD_LAT clocks after raddr
//   vga_hsync    out  horizontal sync, active high
//   vga_vsync    out  vertical sync, active high
//   vga_r/g/b    out  1-bit colour outputs
//   frame_start  out  one-clock pulse with the first window pixel
`timescale 1ns/1ps
module vga_scanout
  import vga_pkg::*;
#(
  parameter int         H_VIS    = DEF_H_VIS,
  parameter int         H_FP     = DEF_H_FP,
  parameter int         H_SW     = DEF_H_SW,
  parameter int         H_BP     = DEF_H_BP,
  parameter int         V_VIS    = DEF_V_VIS,
  parameter int         V_FP     = DEF_V_FP,
  parameter int         V_SW     = DEF_V_SW,
  parameter int         V_BP     = DEF_V_BP,
  parameter int         FB_LINES = 240,
  parameter int         V_OFFSET = 60,
  parameter int         RD_LAT   = 2,
  parameter logic [2:0] FG_RGB   = 3'b010
) (
  input  logic        vgaclk,
  input  logic        reset_n,
  output logic [17:0] raddr,
  input  logic        rdata,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_r,
  output logic        vga_g,
  output logic        vga_b,
  output logic        frame_start
);

  localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;

  localparam hcnt_t    H_LAST    = hcnt_t'(H_TOT - 1);
  localparam hcnt_t    H_VIS_C   = hcnt_t'(H_VIS);
  localparam hcnt_t    H_SYNC_S  = hcnt_t'(H_VIS + H_FP);
  localparam hcnt_t    H_SYNC_E  = hcnt_t'(H_VIS + H_FP + H_SW);
  localparam vcnt_t    V_LAST    = vcnt_t'(V_TOT - 1);
  localparam vcnt_t    V_VIS_C   = vcnt_t'(V_VIS);
  localparam vcnt_t    V_SYNC_S  = vcnt_t'(V_VIS + V_FP);
  localparam vcnt_t    V_SYNC_E  = vcnt_t'(V_VIS + V_FP + V_SW);
  localparam vcnt_t    V_WIN_S   = vcnt_t'(V_OFFSET);
  localparam vcnt_t    V_WIN_E   = vcnt_t'(V_OFFSET + 2 * FB_LINES);
  localparam fb_addr_t STRIDE    = fb_addr_t'(FB_STRIDE);

`ifdef VGA_SCANLINE_EN
  localparam int PW = 6;
`else
  localparam int PW = 5;
`endif

  hcnt_t    hcnt;
  vcnt_t    vcnt;
  vcnt_t    v_next;
  logic     h_wrap;
  vstate_t  vstate;
  fb_addr_t line_base;
  fb_addr_t raddr_q;
  logic     dbl;

  logic hs_raw, vs_raw, de_raw, win_raw, fs_raw;
  logic [PW-1:0] pipe_in, pipe_out;
  logic hs_d, vs_d, de_d, win_d, fs_d, lit;

  assign h_wrap = (hcnt == H_LAST);
  assign v_next = (vcnt == V_LAST) ? '0 : vcnt + vcnt_t'(1);

  // Free-running raster counters; vcnt only moves when a line completes
  always_ff @(posedge vgaclk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (h_wrap) begin
      hcnt <= '0;
      vcnt <= v_next;
    end else begin
      hcnt <= hcnt + hcnt_t'(1);
    end
  end

  // Vertical window FSM. dbl marks the second copy of a doubled line; the
  // framebuffer line base only steps after both copies have been shown,
  // which replaces a 800*line multiply with a running sum.
  always_ff @(posedge vgaclk or negedge reset_n) begin
    if (!reset_n) begin
      vstate    <= V_TOP;
      line_base <= '0;
      dbl       <= 1'b0;
      raddr_q   <= '0;
    end else begin
      raddr_q <= raddr;
      if (h_wrap) begin
        if (v_next == '0) begin
          vstate <= V_TOP;
          dbl    <= 1'b0;
        end else begin
          case (vstate)
            V_TOP: begin
              if (v_next == V_WIN_S) begin
                vstate    <= V_WIN;
                line_base <= '0;
                dbl       <= 1'b0;
              end
            end
            V_WIN: begin
              dbl <= ~dbl;
              if (dbl) line_base <= line_base + STRIDE;
              if (v_next == V_WIN_E) vstate <= V_BOT;
            end
            V_BOT: ;
            default: vstate <= V_TOP;
          endcase
        end
      end
    end
  end

  assign hs_raw  = (hcnt >= H_SYNC_S) && (hcnt < H_SYNC_E);
  assign vs_raw  = (vcnt >= V_SYNC_S) && (vcnt < V_SYNC_E);
  assign de_raw  = (hcnt < H_VIS_C) && (vcnt < V_VIS_C);
  assign win_raw = (vstate == V_WIN) && (hcnt < H_VIS_C);
  assign fs_raw  = (vstate == V_WIN) && (vcnt == V_WIN_S) && (hcnt == '0);

  // The address follows the raster inside the window and otherwise parks
  // on the last address read, so the RAM port is quiet during blanking.
  assign raddr = win_raw ? (line_base + fb_addr_t'(hcnt)) : raddr_q;

`ifdef VGA_SCANLINE_EN
  assign pipe_in = {dbl, fs_raw, win_raw, de_raw, vs_raw, hs_raw};
`else
  assign pipe_in = {fs_raw, win_raw, de_raw, vs_raw, hs_raw};
`endif

  // Timing flags wait RD_LAT clocks so they meet the pixel they describe
  vga_delay_line #(
    .WIDTH (PW),
    .DEPTH (RD_LAT)
  ) u_align (
    .clk   (vgaclk),
    .rst_n (reset_n),
    .din   (pipe_in),
    .dout  (pipe_out)
  );

  assign hs_d  = pipe_out[0];
  assign vs_d  = pipe_out[1];
  assign de_d  = pipe_out[2];
  assign win_d = pipe_out[3];
  assign fs_d  = pipe_out[4];

`ifdef VGA_SCANLINE_EN
  assign lit = de_d && win_d && rdata && !pipe_out[5];
`else
  assign lit = de_d && win_d && rdata;
`endif

  // Final output register; sync and colour share it so they stay aligned
  always_ff @(posedge vgaclk or negedge reset_n) begin
    if (!reset_n) begin
      vga_hsync   <= 1'b0;
      vga_vsync   <= 1'b0;
      vga_r       <= 1'b0;
      vga_g       <= 1'b0;
      vga_b       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      vga_hsync               <= hs_d;
      vga_vsync               <= vs_d;
      {vga_r, vga_g, vga_b}   <= lit ? FG_RGB : 3'b000;
      frame_start             <= fs_d;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout
// Three reduced-timing scanouts (RD_LAT = 1, 2, 3) plus one full
// 800x600 scanout (RD_LAT = 2), each fed by a RAM model with the
// matching read latency.
`timescale 1ns/1ps
module tb_vga_scanout;

  // Reduced raster: 24 clocks per line, 16 lines per frame, 4 fb lines
  localparam int S_HVIS = 16, S_HFP = 2, S_HSW = 3, S_HBP = 3;
  localparam int S_VVIS = 12, S_VFP = 1, S_VSW = 2, S_VBP = 1;
  localparam int S_HTOT = S_HVIS + S_HFP + S_HSW + S_HBP;
  localparam int S_VTOT = S_VVIS + S_VFP + S_VSW + S_VBP;
  localparam int S_FBL  = 4;
  localparam int S_VOFF = 2;
  localparam int D_LAT  = 2;

`ifdef VGA_SCANLINE_EN
  localparam bit SCAN = 1'b1;
`else
  localparam bit SCAN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_s = 1'b1;
  logic rst_d = 1'b1;
  int   scyc;
  int   dcyc;
  int   n_asserts = 0;
  int   n_fails   = 0;

  always #5 clk = ~clk;

  // Clock counts since the last reset release of each DUT group
  always @(posedge clk or negedge rst_s)
    if (!rst_s) scyc <= 0; else scyc <= scyc + 1;
  always @(posedge clk or negedge rst_d)
    if (!rst_d) dcyc <= 0; else dcyc <= dcyc + 1;

  // Diagonal stripe image: lit where (x + fb_line) is a multiple of 3
  function automatic logic fbSmall(input int a);
    return (((a % 800) + (a / 800)) % 3) == 0;
  endfunction

  wire [17:0] s_raddr [1:3];
  wire        s_rdata [1:3];
  wire        s_hs    [1:3];
  wire        s_vs    [1:3];
  wire        s_r     [1:3];
  wire        s_g     [1:3];
  wire        s_b     [1:3];
  wire        s_fs    [1:3];

  for (genvar g = 1; g <= 3; g++) begin : g_small
    logic [3:0] pipe = '0;
    always @(posedge clk) pipe <= {pipe[2:0], fbSmall(int'(s_raddr[g]))};
    assign s_rdata[g] = pipe[g-1];

    vga_scanout #(
      .H_VIS (S_HVIS), .H_FP (S_HFP), .H_SW (S_HSW), .H_BP (S_HBP),
      .V_VIS (S_VVIS), .V_FP (S_VFP), .V_SW (S_VSW), .V_BP (S_VBP),
      .FB_LINES (S_FBL), .V_OFFSET (S_VOFF), .RD_LAT (g), .FG_RGB (3'b010)
    ) dut (
      .vgaclk      (clk),
      .reset_n     (rst_s),
      .raddr       (s_raddr[g]),
      .rdata       (s_rdata[g]),
      .vga_hsync   (s_hs[g]),
      .vga_vsync   (s_vs[g]),
      .vga_r       (s_r[g]),
      .vga_g       (s_g[g]),
      .vga_b       (s_b[g]),
      .frame_start (s_fs[g])
    );
  end

  // Full-size instance; framebuffer holds a single lit pixel at address 5
  logic [17:0] d_raddr;
  logic        d_rdata, d_hs, d_vs, d_r, d_g, d_b, d_fs;
  logic [3:0]  d_pipe = '0;
  always @(posedge clk) d_pipe <= {d_pipe[2:0], (d_raddr == 18'd5)};
  assign d_rdata = d_pipe[D_LAT-1];

  vga_scanout #(.RD_LAT (D_LAT)) dut_full (
    .vgaclk      (clk),
    .reset_n     (rst_d),
    .raddr       (d_raddr),
    .rdata       (d_rdata),
    .vga_hsync   (d_hs),
    .vga_vsync   (d_vs),
    .vga_r       (d_r),
    .vga_g       (d_g),
    .vga_b       (d_b),
    .frame_start (d_fs)
  );

  function automatic logic [5:0] smallPins(input int g);
    return {s_hs[g], s_vs[g], s_r[g], s_g[g], s_b[g], s_fs[g]};
  endfunction

  function automatic logic [5:0] dPins();
    return {d_hs, d_vs, d_r, d_g, d_b, d_fs};
  endfunction

  // Expected pins {hs,vs,r,g,b,fs} of a reduced instance n clocks after
  // reset release, derived from raster position only
  function automatic logic [5:0] expSmall(input int n, input int lat);
    int m, h, v, fl;
    logic hs, vs, de, win, pix, lit, fs;
    if (n < lat + 1) return 6'b0;
    m   = n - (lat + 1);
    h   = m % S_HTOT;
    v   = (m / S_HTOT) % S_VTOT;
    hs  = (h >= S_HVIS + S_HFP) && (h < S_HVIS + S_HFP + S_HSW);
    vs  = (v >= S_VVIS + S_VFP) && (v < S_VVIS + S_VFP + S_VSW);
    de  = (h < S_HVIS) && (v < S_VVIS);
    win = (v >= S_VOFF) && (v < S_VOFF + 2 * S_FBL) && (h < S_HVIS);
    fl  = (v - S_VOFF) / 2;
    pix = win ? fbSmall(800 * fl + h) : 1'b0;
    lit = de && pix && !(SCAN && (((v - S_VOFF) % 2) == 1));
    fs  = (v == S_VOFF) && (h == 0);
    return {hs, vs, 1'b0, lit, 1'b0, fs};
  endfunction

  task automatic applyStimulus(input logic rs, input logic rd);
    rst_s = rs;
    rst_d = rd;
  endtask

  task automatic checkOutput(input string tag, input logic [17:0] obs,
                             input logic [17:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkSmallPins();
    for (int g = 1; g <= 3; g++)
      checkOutput($sformatf("small%0d_pins@%0d", g, scyc),
                  18'(smallPins(g)), 18'(expSmall(scyc, g)));
  endtask

  task automatic waitD(input int n);
    while (dcyc < n) @(negedge clk);
  endtask

  // Hand-computed read addresses of the reduced raster (window lines 2..9)
  int rt_cyc  [10] = '{48, 49, 60, 68, 72, 96, 231, 300, 431, 432};
  int rt_addr [10] = '{0, 1, 12, 15, 0, 800, 2415, 2415, 2415, 0};

  initial begin
    $display("[TB] vga_scanout bench start (scanline=%0d)", SCAN);
    #1 applyStimulus(1'b0, 1'b0);
    repeat (3) @(negedge clk);

    // Everything idle while held in reset
    for (int g = 1; g <= 3; g++) begin
      checkOutput($sformatf("small%0d_reset_pins", g), 18'(smallPins(g)), 18'd0);
      checkOutput($sformatf("small%0d_reset_raddr", g), s_raddr[g], 18'd0);
    end
    checkOutput("full_reset_pins", 18'(dPins()), 18'd0);
    checkOutput("full_reset_raddr", d_raddr, 18'd0);

    // Reduced instances: two-plus frames against the raster model
    applyStimulus(1'b1, 1'b0);
    checkSmallPins();
    while (scyc < 933) begin
      @(negedge clk);
      checkSmallPins();
      for (int i = 0; i < 10; i++)
        if (scyc == rt_cyc[i])
          for (int g = 1; g <= 3; g++)
            checkOutput($sformatf("small%0d_raddr@%0d", g, scyc),
                        s_raddr[g], 18'(rt_addr[i]));
    end

    // Clock 934 is mid-hsync, screen line 6, in every latency build
    @(negedge clk);
    for (int g = 1; g <= 3; g++)
      checkOutput($sformatf("small%0d_hsync_before_reset", g), 18'(s_hs[g]), 18'd1);
    #1 applyStimulus(1'b0, 1'b0);
    #1;
    for (int g = 1; g <= 3; g++) begin
      checkOutput($sformatf("small%0d_async_reset_pins", g), 18'(smallPins(g)), 18'd0);
      checkOutput($sformatf("small%0d_async_reset_raddr", g), s_raddr[g], 18'd0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0);
    checkSmallPins();
    while (scyc < 500) begin
      @(negedge clk);
      checkSmallPins();
      for (int g = 1; g <= 3; g++) begin
        if (scyc == 47 + g + 1)
          checkOutput($sformatf("small%0d_no_early_frame_start", g), 18'(s_fs[g]), 18'd0);
        if (scyc == 48 + g + 1)
          checkOutput($sformatf("small%0d_first_frame_start", g), 18'(s_fs[g]), 18'd1);
      end
    end

    // Full-size instance
    checkOutput("full_held_reset_pins", 18'(dPins()), 18'd0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("full_release_pins", 18'(dPins()), 18'd0);
    checkOutput("full_release_raddr", d_raddr, 18'd0);
    waitD(842);   checkOutput("full_hsync_pre", 18'(d_hs), 18'd0);
    waitD(843);   checkOutput("full_hsync_rise", 18'(d_hs), 18'd1);
                  checkOutput("full_vsync_line0", 18'(d_vs), 18'd0);
    waitD(970);   checkOutput("full_hsync_last", 18'(d_hs), 18'd1);
    waitD(971);   checkOutput("full_hsync_fall", 18'(d_hs), 18'd0);
    waitD(62312); checkOutput("full_line59_x5", 18'(dPins()), 18'd0);
    waitD(63362); checkOutput("full_fs_early", 18'(d_fs), 18'd0);
    waitD(63363); checkOutput("full_frame_start", 18'(dPins()), 18'b000001);
    waitD(63364); checkOutput("full_fs_after", 18'(dPins()), 18'd0);
    waitD(63365); checkOutput("full_raddr_l60_x5", d_raddr, 18'd5);
    waitD(63367); checkOutput("full_line60_x4", 18'(dPins()), 18'd0);
    waitD(63368); checkOutput("full_line60_x5", 18'(dPins()), 18'b000100);
    waitD(63369); checkOutput("full_line60_x6", 18'(dPins()), 18'd0);
    waitD(64419); checkOutput("full_line61_no_fs", 18'(dPins()), 18'd0);
    waitD(64421); checkOutput("full_raddr_l61_x5", d_raddr, 18'd5);
    waitD(64424); checkOutput("full_line61_x5", 18'(dPins()),
                              SCAN ? 18'd0 : 18'b000100);
    waitD(65477); checkOutput("full_raddr_l62_x5", d_raddr, 18'd805);
    waitD(65480); checkOutput("full_line62_x5", 18'(dPins()), 18'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
